adder_result_fifo: RTL and testbench

- Downstream consumer of the 4-bit ripple adder (FullAdder4bit): captures each {overflow, carryout, sum} result into a small FIFO under a valid/ready handshake.
- Keeps running statistics: sticky overflow flag and saturating overflow/carry-out event counters.
- Lets a slower sink (display/checker stage) drain results at its own rate without losing adder outputs.

---
 rtl/adder_result_fifo.sv | 138 +++++++++++++
 tb/tb_adder_result_fifo.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_result_fifo.sv
// adder_result_fifo
// -----------------
// Collects the {overflow, carryout, sum} results of the 4-bit ripple adder
// into a small FIFO. A slower sink can then drain them at its own pace.
// The block also keeps a sticky overflow flag and two saturating event
// counters: one for overflow events and one for carry-out events.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   in_sum       adder sum, index 0 is the MSB
//   in_carryout  adder carry-out
//   in_overflow  adder signed overflow
//   in_valid     producer has a valid result
//   in_ready     FIFO can take an entry (depends on registered state only)
//   out_data     head entry {overflow, carryout, sum}, index 0 = overflow; 0 when empty
//   out_valid    FIFO non-empty
//   out_ready    sink takes the head entry
//   level        current occupancy
//   sticky_ovf   set by any accepted overflow entry
//   clear_flags  clears sticky_ovf and both counters
//   ovf_count    saturating count of accepted overflow entries
//   cout_count   saturating count of accepted carry-out entries
module adder_result_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [0:WIDTH-1]             in_sum,
    input  logic                         in_carryout,
    input  logic                         in_overflow,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [0:WIDTH+1]             out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         sticky_ovf,
    input  logic                         clear_flags,
    output logic [CNT_W-1:0]             ovf_count,
    output logic [CNT_W-1:0]             cout_count
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = WIDTH + 2;

    logic [0:ENTRY_W-1] mem_q [DEPTH];
    logic [0:ENTRY_W-1] mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               sticky_q, sticky_d;
    logic [CNT_W-1:0]   ovf_cnt_q, ovf_cnt_d;
    logic [CNT_W-1:0]   cout_cnt_q, cout_cnt_d;

    logic push;
    logic pop;

    // A clear that coincides with a push starts the counter from zero.
    // The pushed event is still added, so it is never lost.
    function automatic logic [CNT_W-1:0] next_count(
        input logic [CNT_W-1:0] cur,
        input logic             clr,
        input logic             inc
    );
        logic [CNT_W-1:0] base;
        base = clr ? '0 : cur;
        if (inc && (base != '1)) begin
            base = base + CNT_W'(1);
        end
        return base;
    endfunction

    // The handshake flags are decoded from registered occupancy only.
    assign in_ready  = (level_q != LVL_W'(DEPTH));
    assign out_valid = (level_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign level      = level_q;
    assign sticky_ovf = sticky_q;
    assign ovf_count  = ovf_cnt_q;
    assign cout_count = cout_cnt_q;

    always_comb begin
        push = in_valid && in_ready;
        pop  = out_valid && out_ready;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (push) begin
            mem_d[wr_ptr_q] = {in_overflow, in_carryout, in_sum};
            // DEPTH is a power of two, so the pointer wraps naturally.
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        sticky_d   = clear_flags ? (push && in_overflow)
                                 : (sticky_q || (push && in_overflow));
        ovf_cnt_d  = next_count(ovf_cnt_q,  clear_flags, push && in_overflow);
        cout_cnt_d = next_count(cout_cnt_q, clear_flags, push && in_carryout);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            sticky_q   <= 1'b0;
            ovf_cnt_q  <= '0;
            cout_cnt_q <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            sticky_q   <= sticky_d;
            ovf_cnt_q  <= ovf_cnt_d;
            cout_cnt_q <= cout_cnt_d;
        end
    end

endmodule

// File: tb/tb_adder_result_fifo.sv
// tb_adder_result_fifo
// --------------------
// Bench for adder_result_fifo. It drives two instances from the same inputs:
//   dut      uses the default 8-bit counters.
//   dut_sat  uses 2-bit counters so that saturation is reachable quickly.
// The reference model is a queue of entries plus integer counters clamped
// to their maximum. Expected adder results come from plain integer addition.
module tb_adder_result_fifo;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [0:3] in_sum = '0;
    logic       in_carryout = 1'b0;
    logic       in_overflow = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [0:5] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] level;
    logic       sticky_ovf;
    logic       clear_flags = 1'b0;
    logic [7:0] ovf_count;
    logic [7:0] cout_count;

    logic       s_in_ready;
    logic [0:5] s_out_data;
    logic       s_out_valid;
    logic [2:0] s_level;
    logic       s_sticky_ovf;
    logic [1:0] s_ovf_count;
    logic [1:0] s_cout_count;

    int tests = 0;
    int failures = 0;

    // Reference model state.
    logic [5:0] mq[$];
    int  mSticky = 0;
    int  mOvf = 0;
    int  mCout = 0;
    int  mOvfSat = 0;
    int  mCoutSat = 0;
    bit  lastAccepted = 1'b0;

    adder_result_fifo #(.WIDTH(4), .DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_sum(in_sum), .in_carryout(in_carryout),
        .in_overflow(in_overflow), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .sticky_ovf(sticky_ovf), .clear_flags(clear_flags),
        .ovf_count(ovf_count), .cout_count(cout_count)
    );

    adder_result_fifo #(.WIDTH(4), .DEPTH(DEPTH), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .in_sum(in_sum), .in_carryout(in_carryout),
        .in_overflow(in_overflow), .in_valid(in_valid), .in_ready(s_in_ready),
        .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(out_ready),
        .level(s_level), .sticky_ovf(s_sticky_ovf), .clear_flags(clear_flags),
        .ovf_count(s_ovf_count), .cout_count(s_cout_count)
    );

    always #5 clk = ~clk;

    // Computes the 4-bit adder result as {overflow, carryout, sum}.
    function automatic logic [5:0] adderResult(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        logic       ovf;
        s   = {1'b0, a} + {1'b0, b};
        ovf = (a[3] == b[3]) && (s[3] != a[3]);
        return {ovf, s[4], s[3:0]};
    endfunction

    function automatic int clampAdd(input int base, input int inc, input int maxv);
        return (base + inc > maxv) ? maxv : base + inc;
    endfunction

    task automatic checkVal(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Compares every DUT output with the reference model.
    task automatic checkOutput(input string tag);
        int expData;
        expData = (mq.size() != 0) ? int'(mq[0]) : 0;
        checkVal({tag, " level"},      int'(level),      mq.size());
        checkVal({tag, " out_valid"},  int'(out_valid),  int'(mq.size() != 0));
        checkVal({tag, " in_ready"},   int'(in_ready),   int'(mq.size() != DEPTH));
        checkVal({tag, " out_data"},   int'(out_data),   expData);
        checkVal({tag, " sticky"},     int'(sticky_ovf), mSticky);
        checkVal({tag, " ovf_count"},  int'(ovf_count),  mOvf);
        checkVal({tag, " cout_count"}, int'(cout_count), mCout);
        checkVal({tag, " sat ovf"},    int'(s_ovf_count),  mOvfSat);
        checkVal({tag, " sat cout"},   int'(s_cout_count), mCoutSat);
        checkVal({tag, " sat level"},  int'(s_level),      mq.size());
    endtask

    // Drives one cycle of inputs, advances the model and steps the clock.
    task automatic applyStimulus(input bit rst, input bit valid, input logic [3:0] a,
                                 input logic [3:0] b, input bit oready, input bit clr);
        logic [5:0] r;
        bit push;
        bit pop;
        r = adderResult(a, b);
        reset       = rst;
        in_valid    = valid;
        in_overflow = r[5];
        in_carryout = r[4];
        in_sum      = r[3:0];
        out_ready   = oready;
        clear_flags = clr;

        push = valid && (mq.size() < DEPTH);
        pop  = oready && (mq.size() > 0);
        lastAccepted = push && !rst;
        if (rst) begin
            mq.delete();
            mSticky = 0; mOvf = 0; mCout = 0; mOvfSat = 0; mCoutSat = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(r);
            if (clr) begin
                mSticky = 0; mOvf = 0; mCout = 0; mOvfSat = 0; mCoutSat = 0;
            end
            if (push) begin
                if (r[5]) mSticky = 1;
                mOvf     = clampAdd(mOvf,     int'(r[5]), 255);
                mCout    = clampAdd(mCout,    int'(r[4]), 255);
                mOvfSat  = clampAdd(mOvfSat,  int'(r[5]), 3);
                mCoutSat = clampAdd(mCoutSat, int'(r[4]), 3);
            end
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit         rst;
        bit         valid;
        logic [3:0] a;
        logic [3:0] b;
        bit         oready;
        bit         clr;
        int         lvl;
        int         ovalid;
        int         iready;
        int         data;
        int         sticky;
        int         ovfc;
        int         coutc;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [3:0] ra;
        logic [3:0] rb;
        bit         rv;
        int         satExp[5];

        // rst valid  a      b      ordy clr | lvl ov ir data        stk ovf cout
        vecs[0] = '{1, 0, 4'd0,  4'd0,  0, 0, 0, 0, 1, 0,             0, 0, 0};
        vecs[1] = '{0, 1, 4'd4,  4'd4,  0, 0, 1, 1, 1, 6'b10_1000,    1, 1, 0};
        vecs[2] = '{0, 1, 4'd12, 4'd12, 0, 0, 2, 1, 1, 6'b10_1000,    1, 1, 1};
        vecs[3] = '{0, 1, 4'd15, 4'd15, 0, 0, 3, 1, 1, 6'b10_1000,    1, 1, 2};
        vecs[4] = '{0, 1, 4'd1,  4'd2,  0, 0, 4, 1, 0, 6'b10_1000,    1, 1, 2};
        vecs[5] = '{0, 1, 4'd7,  4'd7,  0, 0, 4, 1, 0, 6'b10_1000,    1, 1, 2};
        vecs[6] = '{0, 0, 4'd0,  4'd0,  1, 0, 3, 1, 1, 6'b01_1000,    1, 1, 2};

        #1;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].a, vecs[i].b,
                          vecs[i].oready, vecs[i].clr);
            checkVal($sformatf("vec%0d level", i),    int'(level),      vecs[i].lvl);
            checkVal($sformatf("vec%0d out_valid", i), int'(out_valid), vecs[i].ovalid);
            checkVal($sformatf("vec%0d in_ready", i), int'(in_ready),   vecs[i].iready);
            checkVal($sformatf("vec%0d out_data", i), int'(out_data),   vecs[i].data);
            checkVal($sformatf("vec%0d sticky", i),   int'(sticky_ovf), vecs[i].sticky);
            checkVal($sformatf("vec%0d ovf_count", i), int'(ovf_count), vecs[i].ovfc);
            checkVal($sformatf("vec%0d cout_count", i), int'(cout_count), vecs[i].coutc);
        end

        // Drain to level 2, then clear with no push: the counters clear
        // and the FIFO contents stay put.
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("drain");
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("clear");
        checkVal("clear level kept", int'(level), 2);
        checkVal("clear sticky", int'(sticky_ovf), 0);

        // Steady streaming at level 2 across the pointer wrap.
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) applyStimulus(0, 1, 4'd12, 4'd12, 1, 0);
            else            applyStimulus(0, 1, 4'd15, 4'd15, 1, 0);
            checkOutput($sformatf("stream%0d", i));
            checkVal($sformatf("stream%0d level", i), int'(level), 2);
        end
        checkVal("stream cout_count", int'(cout_count), 6);

        // A clear that coincides with an overflow push keeps the new event.
        applyStimulus(0, 1, 4'd4, 4'd4, 0, 1);
        checkOutput("clear+push");
        checkVal("clear+push sticky", int'(sticky_ovf), 1);
        checkVal("clear+push ovf_count", int'(ovf_count), 1);

        // Saturation of the 2-bit instance while streaming at level 3.
        applyStimulus(0, 0, 0, 0, 0, 1);
        satExp = '{1, 2, 3, 3, 3};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 4'd12, 4'd12, 1, 0);
            checkOutput($sformatf("sat%0d", i));
            checkVal($sformatf("sat%0d cout", i), int'(s_cout_count), satExp[i]);
        end

        // A reset at level 3 with in_valid high stores nothing.
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkVal("pre-reset level", int'(level), 3);
        applyStimulus(1, 1, 4'd5, 4'd6, 0, 0);
        checkOutput("reset");
        checkVal("reset level", int'(level), 0);
        checkVal("reset out_data", int'(out_data), 0);
        checkVal("reset in_ready", int'(in_ready), 1);
        checkVal("reset cout", int'(cout_count), 0);

        // Randomized traffic against the model. The producer holds an
        // unaccepted entry stable.
        rv = 0; ra = 0; rb = 0;
        for (int i = 0; i < 400; i++) begin
            if (!(rv && !lastAccepted)) begin
                rv = ($urandom_range(0, 3) != 0);
                ra = 4'($urandom_range(0, 15));
                rb = 4'($urandom_range(0, 15));
            end
            applyStimulus(($urandom_range(0, 63) == 0), rv, ra, rb,
                          ($urandom_range(0, 2) == 0), ($urandom_range(0, 31) == 0));
            checkOutput($sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
